sample_fifo_fwft: RTL and testbench
===================================

# sample_fifo_fwft

Single-clock, first-word-fall-through byte FIFO that buffers samples from the host/byte-source side and feeds the PSK modulator stage. The head word is presented on `dout` whenever `empty` is low, so the consumer can latch `dout` in the same cycle it pulses `rd`. Occupancy, threshold and sticky error flags support upstream flow control and debug.

## Interface
Parameters:
- `DATA_WIDTH`, 8, word width in bits.
- `ADDR_WIDTH`, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16).
- `AFULL_THRESH`, 12, `almost_full` asserts when level >= this value; legal range 1..DEPTH.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  DATA_WIDTH  write data.
- `wr`  in  1  write strobe, one word per cycle.
- `full`  out  1  level == DEPTH.
- `almost_full`  out  1  level >= AFULL_THRESH.
- `dout`  out  DATA_WIDTH  head-of-queue word; forced to 0 while `empty`=1.
- `empty`  out  1  level == 0.
- `rd`  in  1  pop strobe; consumer samples `dout` in the same cycle.
- `level`  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was dropped.
- `underflow`  out  1  sticky: a pop was attempted while empty.
- `clr_err`  in  1  clears both sticky flags.

## Operation
- Storage: DEPTH x DATA_WIDTH register array; write pointer `wp` and read pointer `rp`, ADDR_WIDTH bits each, wrap modulo DEPTH with no special handling; occupancy held in a registered counter `cnt`.
- Derived outputs:
  - `empty`, `full`, `almost_full` and `level` are functions of `cnt` only.
  - `dout = empty ? 0 : mem[rp]`.
  - No combinational path from `wr`, `din` or `rd` to any output.
- Accept rules, evaluated each cycle:
  - `wr_ok = wr & (~full | rd_ok)`.
  - `rd_ok = rd & ~empty`.
- `wr_ok`: `mem[wp] <= din`, `wp <= wp+1`.
- `rd_ok`: `rp <= rp+1`.
- `cnt` update:
  - +1 on `wr_ok` only.
  - -1 on `rd_ok` only.
  - Unchanged when both or neither occur.
- Full with `wr` and `rd` in the same cycle: both are accepted and level stays DEPTH.
- Empty with `wr` and `rd` in the same cycle: the write is accepted, the read is ignored, `underflow` is set and level becomes 1.
- `wr & ~wr_ok` sets `overflow`; `din` is discarded and no state changes.
- `rd & empty` sets `underflow`; no pointer movement.
- `clr_err` clears both sticky flags. A new error in the same cycle takes priority and leaves its flag at 1.
- Reset:
  - `wp`, `rp`, `cnt` and both flags are cleared.
  - Memory contents are not cleared; they are unreachable after reset.

## Timing
- Reset values: `empty`=1, `full`=0, `almost_full`=0, `level`=0, `dout`=0, `overflow`=0, `underflow`=0.
- Reset takes priority over `wr`/`rd`/`clr_err` in the same cycle. Reset mid-operation empties the FIFO on the next edge; the first post-reset write is visible one cycle later.
- Write-to-visible latency is 1 cycle: a word written at edge N gives `empty`=0 and `dout`=word after edge N.
- Pop latency is 1 cycle: after the edge sampling `rd_ok`, `dout` shows the next word, or `empty`=1 if the popped word was the last.
- `full` deasserts 1 cycle after a pop from full. `almost_full` tracks `cnt` with the same 1-cycle latency.
- Sustained throughput is one write and one read per cycle at any occupancy.

## Test plan
- Reset, then write 0x01..0x10 on consecutive cycles with no reads:
  - `level` counts 1..16.
  - `almost_full` rises after the 12th write.
  - `full`=1 after the 16th write.
  - `dout`=0x01 throughout.
- From full, pop 16 times back-to-back: `dout` sequence is 0x01..0x10, `empty`=1 after the last pop, `dout`=0, no flags set.
- Overflow and clear:
  - 17th write while full with `rd`=0: 0x11 is dropped and `overflow`=1.
  - Assert `clr_err`: `overflow` returns to 0.
  - Assert `clr_err` together with another bad write: `overflow` stays 1.
- Pop while empty: `underflow`=1 and `level` stays 0. Then `wr`+`rd` while empty with `din`=0xA5: `level`=1, `dout`=0xA5, `underflow` still 1.
- Stress across pointer wrap: simultaneous `wr`/`rd` for 40 cycles at level 16 and again at level 5. Level is constant and output order matches a scoreboard.
- Write 0x5A, 0x3C, assert `rst` for 1 cycle mid-stream, then write 0x77:
  - The cycle after `rst`: `empty`=1, `level`=0.
  - After the new write: `dout`=0x77, not 0x5A.

Source files
------------

// File: rtl/sample_fifo_fwft_if.sv
// Handshake bundle between a byte source/consumer and the FWFT sample FIFO.
interface sample_fifo_fwft_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] din;
    logic                  wr;
    logic                  full;
    logic                  almost_full;
    logic [DATA_WIDTH-1:0] dout;
    logic                  empty;
    logic                  rd;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;
    logic                  clr_err;

    modport master (
        output din, wr, rd, clr_err,
        input  full, almost_full, dout, empty, level, overflow, underflow
    );

    modport slave (
        input  din, wr, rd, clr_err,
        output full, almost_full, dout, empty, level, overflow, underflow
    );
endinterface

// File: rtl/sample_fifo_fwft.sv
// First-word-fall-through byte FIFO feeding the PSK modulator; head word is always on dout.
module sample_fifo_fwft #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned AFULL_THRESH = 12
) (
    input logic                clk,
    input logic                rst,
    sample_fifo_fwft_if.slave  bus
);
    localparam int unsigned       Depth     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(Depth);
    localparam logic [ADDR_WIDTH:0] AfullCnt = (ADDR_WIDTH + 1)'(AFULL_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [Depth];
    logic [ADDR_WIDTH-1:0] r_wp;
    logic [ADDR_WIDTH-1:0] r_rp;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_ovf;
    logic                  r_unf;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == DepthCnt);
    assign w_rd_ok = bus.rd & ~w_empty;
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign w_wr_ok = bus.wr & (~w_full | w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wp] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_wr_ok) r_wp <= r_wp + 1'b1;
            if (w_rd_ok) r_rp <= r_rp + 1'b1;
            if (w_wr_ok && !w_rd_ok) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_rd_ok && !w_wr_ok) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // Later assignments win: a fresh error overrides clr_err.
            if (bus.clr_err) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            if (bus.wr && !w_wr_ok) r_ovf <= 1'b1;
            if (bus.rd && w_empty)  r_unf <= 1'b1;
        end
    end

    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.almost_full = (r_cnt >= AfullCnt);
    assign bus.level       = r_cnt;
    assign bus.dout        = w_empty ? '0 : r_mem[r_rp];
    assign bus.overflow    = r_ovf;
    assign bus.underflow   = r_unf;
endmodule

// File: tb/tb_sample_fifo_fwft.sv
// Scoreboard bench for sample_fifo_fwft: fill/drain, sticky errors, wrap stress, mid-stream reset.
module tb_sample_fifo_fwft;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [7:0] sb_q[$];

    sample_fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

    sample_fifo_fwft #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .AFULL_THRESH(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one edge; inputs were set beforehand, outputs are sampled 1 time unit after.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr = 1'b0; bus.rd = 1'b0; bus.clr_err = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        bus.din = d; bus.wr = 1'b1; bus.rd = 1'b0;
        sb_q.push_back(d);
        cycle();
        idle();
    endtask

    task automatic check_head(input string tag);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            check(tag, {24'd0, bus.dout}, {24'd0, sb_q[0]});
        end
    endtask

    task automatic pop_word(input string tag);
        check_head(tag);
        if (sb_q.size() != 0) void'(sb_q.pop_front());
        bus.wr = 1'b0; bus.rd = 1'b1;
        cycle();
        idle();
    endtask

    task automatic stress(input int exp_level, input string tag);
        logic [7:0] d;
        for (int i = 0; i < 40; i++) begin
            check_head(tag);
            void'(sb_q.pop_front());
            d = 8'($urandom_range(0, 255));
            sb_q.push_back(d);
            bus.din = d; bus.wr = 1'b1; bus.rd = 1'b1;
            cycle();
            check({tag, "_level"}, {27'd0, bus.level}, exp_level);
        end
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.din  = '0;
        idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;

        check("rst_empty", {31'd0, bus.empty}, 1);
        check("rst_full", {31'd0, bus.full}, 0);
        check("rst_afull", {31'd0, bus.almost_full}, 0);
        check("rst_level", {27'd0, bus.level}, 0);
        check("rst_dout", {24'd0, bus.dout}, 0);
        check("rst_ovf", {31'd0, bus.overflow}, 0);
        check("rst_unf", {31'd0, bus.underflow}, 0);

        // Fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            push_word(8'(i));
            check("fill_level", {27'd0, bus.level}, i);
            check("fill_afull", {31'd0, bus.almost_full}, (i >= 12) ? 1 : 0);
            check("fill_full", {31'd0, bus.full}, (i == 16) ? 1 : 0);
            check("fill_dout", {24'd0, bus.dout}, 8'h01);
        end

        // Overflow while full, then sticky clear behaviour
        bus.din = 8'h11; bus.wr = 1'b1;
        cycle();
        idle();
        check("ovf_set", {31'd0, bus.overflow}, 1);
        check("ovf_level", {27'd0, bus.level}, 16);
        bus.clr_err = 1'b1;
        cycle();
        idle();
        check("ovf_clr", {31'd0, bus.overflow}, 0);
        bus.clr_err = 1'b1; bus.din = 8'h22; bus.wr = 1'b1;
        cycle();
        idle();
        check("ovf_clr_prio", {31'd0, bus.overflow}, 1);
        bus.clr_err = 1'b1;
        cycle();
        idle();
        check("ovf_clr2", {31'd0, bus.overflow}, 0);

        // Drain back-to-back
        for (int i = 0; i < 16; i++) begin
            check_head("drain_dout");
            void'(sb_q.pop_front());
            bus.rd = 1'b1;
            cycle();
            if (i == 0) check("full_deassert", {31'd0, bus.full}, 0);
        end
        idle();
        check("drain_empty", {31'd0, bus.empty}, 1);
        check("drain_dout0", {24'd0, bus.dout}, 0);
        check("drain_ovf", {31'd0, bus.overflow}, 0);
        check("drain_unf", {31'd0, bus.underflow}, 0);

        // Underflow, then write+read while empty
        bus.rd = 1'b1;
        cycle();
        idle();
        check("unf_set", {31'd0, bus.underflow}, 1);
        check("unf_level", {27'd0, bus.level}, 0);
        bus.din = 8'hA5; bus.wr = 1'b1; bus.rd = 1'b1;
        sb_q.push_back(8'hA5);
        cycle();
        idle();
        check("wr_rd_empty_level", {27'd0, bus.level}, 1);
        check("wr_rd_empty_dout", {24'd0, bus.dout}, 8'hA5);
        check("wr_rd_empty_unf", {31'd0, bus.underflow}, 1);
        pop_word("a5_pop");
        bus.clr_err = 1'b1;
        cycle();
        idle();
        check("unf_clr", {31'd0, bus.underflow}, 0);

        // Wrap stress at level 16 and level 5
        for (int i = 0; i < 16; i++) push_word(8'($urandom_range(0, 255)));
        stress(16, "stress16");
        check("stress16_full", {31'd0, bus.full}, 1);
        for (int i = 0; i < 11; i++) pop_word("drain_to5");
        check("lvl5", {27'd0, bus.level}, 5);
        stress(5, "stress5");
        while (sb_q.size() != 0) pop_word("final_drain");
        check("stress_empty", {31'd0, bus.empty}, 1);
        check("stress_flags", {30'd0, bus.overflow, bus.underflow}, 0);

        // Mid-stream reset
        push_word(8'h5A);
        push_word(8'h3C);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sb_q.delete();
        check("rst_mid_empty", {31'd0, bus.empty}, 1);
        check("rst_mid_level", {27'd0, bus.level}, 0);
        push_word(8'h77);
        check("rst_mid_dout", {24'd0, bus.dout}, 8'h77);
        check("rst_mid_level1", {27'd0, bus.level}, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
